y86_regfile_wb: RTL and testbench
=================================

# y86_regfile_wb

Parametrised Y86-64 register file with an integrated writeback stage. It replaces the combinational register-array pass-through with clocked storage and two write ports (E and M) decoded from `icode`/`cnd`. It adds a valid/ready handshake, same-cycle write-through bypass on two read ports, a halt/invalid-instruction status state machine, and a retired-instruction counter. It sits between the memory stage and decode: decode reads it, and the memory stage presents one instruction per cycle for retirement.

## Interface
Parameters:
- DATA_W, 64, register and data width
- NREGS, 15, number of architectural registers; IDs >= NREGS (including 4'hF = RNONE) are never written and read as 0
- CNT_W, 32, width of the retired-instruction counter
- RSP_ID, 4, register ID updated by call/ret/pushq/popq

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wb_valid  in  1  an instruction is presented for writeback
- wb_ready  out  1  block accepts the instruction this cycle
- icode  in  4  instruction code
- cnd  in  1  condition result (used by cmovXX)
- rA  in  4  register A field
- rB  in  4  register B field
- valE  in  DATA_W  execute result
- valM  in  DATA_W  memory result
- srcA  in  4  read port A address
- srcB  in  4  read port B address
- rdA  out  DATA_W  read port A data (combinational)
- rdB  out  DATA_W  read port B data (combinational)
- stat  out  3  1=AOK, 2=HLT, 4=INS
- retired  out  CNT_W  count of accepted valid instructions

## Operation
- Accept condition: `acc = wb_valid & wb_ready`. `wb_ready = (state == RUN)`.
- Destination decode:
  - 2 (cmovXX): dstE = cnd ? rB : none
  - 3 (irmovq): dstE = rB
  - 6 (OPq): dstE = rB
  - 5 (mrmovq): dstM = rA
  - 8 (call), 9 (ret), A (pushq): dstE = RSP_ID
  - B (popq): dstE = RSP_ID and dstM = rA
  - 0 (halt), 1 (nop), 4 (rmmovq), 7 (jXX): no write
- Write port E writes valE into dstE. Write port M writes valM into dstM. Both happen only on `acc`, and only when the destination is < NREGS.
- When dstE == dstM (popq %rsp), M wins: the register receives valM.
- Read ports:
  - If the address is >= NREGS, the result is 0.
  - Otherwise, if `acc` is true this cycle and the address matches a pending destination, return the pending value, with M priority over E (write-through bypass).
  - Otherwise return the stored value.
- State machine (reset to RUN):
  - RUN -> HLT on acc of icode 0.
  - RUN -> INS on acc of icode > 4'hB. That instruction writes nothing.
  - HLT and INS are terminal until rst_n is asserted. In these states `wb_ready` = 0, no writes occur, and `retired` is frozen.
- `stat` encodes the current state: RUN=1, HLT=2, INS=4.
- `retired` increments by 1 on each acc with icode <= 4'hB (halt counts; INS does not). It saturates at all-ones and does not wrap.

## Timing
- Reset (async assert, sync-safe deassert) sets:
  - all registers to 0
  - `stat` to 1
  - `retired` to 0
  - `wb_ready` to 1
- Write latency: a value accepted in cycle N is stored at the rising edge ending cycle N.
  - Via bypass it is visible on rdA/rdB during cycle N.
  - From storage it is visible in cycle N+1 onward.
- State transition to HLT/INS takes effect at that same edge, so `wb_ready` drops in cycle N+1. The halting instruction itself is accepted.
- `wb_valid` while `wb_ready` = 0 has no effect. The upstream holds or drops the instruction; this block does not buffer it.
- rdA/rdB have a purely combinational path from srcA/srcB, icode, rA, rB, cnd, valE, valM, wb_valid.
- rst_n asserted mid-cycle clears all state immediately, independent of clk. A write in flight in that cycle is lost.

## Test plan
- Reset, then read all 16 IDs: every rdA/rdB = 0, stat = 1, retired = 0, wb_ready = 1.
- irmovq (icode 3, rB=2, valE=0x1234) with srcA=2 in the same cycle: rdA = 0x1234 via bypass. Next cycle, with wb_valid=0, rdA = 0x1234 from storage. retired = 1.
- cmovXX (icode 2, rB=3, valE=0x55):
  - with cnd=0, reg 3 stays 0;
  - repeat with cnd=1, reg 3 = 0x55.
  - retired increments on both.
- popq %rsp (icode B, rA=4, valE=0x100, valM=0xABC): reg 4 = 0xABC, and the bypass also returns 0xABC. popq rA=1 with the same values: reg 4 = 0x100, reg 1 = 0xABC.
- halt (icode 0): stat = 2 next cycle, wb_ready = 0, retired +1. A following irmovq to reg 5 is ignored (reg 5 unchanged). After pulsing rst_n: stat = 1 and all registers = 0.
- icode 4'hC with rB=6: no write, stat = 4, retired unchanged. With CNT_W=2, five nops saturate retired at 3.

Source files
------------

// File: rtl/y86_regfile_wb_if.sv
// Writeback/read bus between the memory stage, decode and the Y86-64 register file.
interface y86_regfile_wb_if #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
);
    logic              wb_valid;
    logic              wb_ready;
    logic [3:0]        icode;
    logic              cnd;
    logic [3:0]        rA;
    logic [3:0]        rB;
    logic [DATA_W-1:0] valE;
    logic [DATA_W-1:0] valM;
    logic [3:0]        srcA;
    logic [3:0]        srcB;
    logic [DATA_W-1:0] rdA;
    logic [DATA_W-1:0] rdB;
    logic [2:0]        stat;
    logic [CNT_W-1:0]  retired;

    // Upstream side: presents instructions and read addresses.
    modport master (
        output wb_valid, icode, cnd, rA, rB, valE, valM, srcA, srcB,
        input  wb_ready, rdA, rdB, stat, retired
    );

    // Register file side.
    modport slave (
        input  wb_valid, icode, cnd, rA, rB, valE, valM, srcA, srcB,
        output wb_ready, rdA, rdB, stat, retired
    );
endinterface

// File: rtl/y86_regfile_wb.sv
// Y86-64 register file with integrated writeback: two write ports (E, M)
// decoded from icode/cnd, write-through bypass on both read ports,
// halt/invalid-instruction status FSM and a saturating retired counter.
module y86_regfile_wb #(
    parameter int         DATA_W = 64,
    parameter int         NREGS  = 15,
    parameter int         CNT_W  = 32,
    parameter logic [3:0] RSP_ID = 4'd4
) (
    input  logic             clk,
    input  logic             rst_n,
    y86_regfile_wb_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_RUN = 3'b001,
        ST_HLT = 3'b010,
        ST_INS = 3'b100
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [DATA_W-1:0] reg_file [NREGS];

    logic       acc;
    logic [3:0] dst_e, dst_m;
    logic       e_en, m_en;
    logic       wr_e, wr_m;

    assign bus.wb_ready = (state_q == ST_RUN);
    assign acc          = bus.wb_valid & bus.wb_ready;
    assign bus.stat     = state_q;
    assign bus.retired  = retired_q;

    // Destination decode; codes above 4'hB fall to the default and write nothing.
    always_comb begin
        dst_e = 4'hF;
        dst_m = 4'hF;
        e_en  = 1'b0;
        m_en  = 1'b0;
        case (bus.icode)
            4'h2: begin dst_e = bus.rB; e_en = bus.cnd; end
            4'h3, 4'h6: begin dst_e = bus.rB; e_en = 1'b1; end
            4'h5: begin dst_m = bus.rA; m_en = 1'b1; end
            4'h8, 4'h9, 4'hA: begin dst_e = RSP_ID; e_en = 1'b1; end
            4'hB: begin
                dst_e = RSP_ID; e_en = 1'b1;
                dst_m = bus.rA; m_en = 1'b1;
            end
            default: ;
        endcase
    end

    // Writes only happen on accept and only to implemented registers.
    assign wr_e = acc & e_en & (32'(dst_e) < NREGS);
    assign wr_m = acc & m_en & (32'(dst_m) < NREGS);

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            logic [DATA_W-1:0] reg_q;
            // Per-register storage; port M overrides port E on a shared destination.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    reg_q <= '0;
                else if (wr_m && dst_m == 4'(gi))
                    reg_q <= bus.valM;
                else if (wr_e && dst_e == 4'(gi))
                    reg_q <= bus.valE;
            end
            assign reg_file[gi] = reg_q;
        end
    endgenerate

    // Read with write-through bypass: M before E before stored value.
    function automatic logic [DATA_W-1:0] rd_port(input logic [3:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (32'(addr) < NREGS) begin
            if (wr_m && addr == dst_m)
                val = bus.valM;
            else if (wr_e && addr == dst_e)
                val = bus.valE;
            else
                val = reg_file[addr];
        end
        return val;
    endfunction

    // Combinational read ports A and B.
    always_comb begin
        bus.rdA = rd_port(bus.srcA);
        bus.rdB = rd_port(bus.srcB);
    end

    // Status next-state and retired-counter next-value.
    always_comb begin
        state_d   = state_q;
        retired_d = retired_q;
        if (acc) begin
            if (bus.icode == 4'h0)
                state_d = ST_HLT;
            else if (bus.icode > 4'hB)
                state_d = ST_INS;
            if (bus.icode <= 4'hB && retired_q != {CNT_W{1'b1}})
                retired_d = retired_q + CNT_W'(1);
        end
    end

    // Status and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end
endmodule

// File: tb/tb_y86_regfile_wb.sv
// Scoreboard bench for y86_regfile_wb: stimulus pushes expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_y86_regfile_wb;
    localparam int K_RDA   = 0;
    localparam int K_RDB   = 1;
    localparam int K_STAT  = 2;
    localparam int K_RET   = 3;
    localparam int K_READY = 4;
    localparam int K_RET_S = 5;

    logic clk;
    logic rst_n;

    y86_regfile_wb_if #(.DATA_W(64), .CNT_W(32)) m_if ();
    y86_regfile_wb_if #(.DATA_W(64), .CNT_W(2))  s_if ();

    y86_regfile_wb #(.DATA_W(64), .NREGS(15), .CNT_W(32), .RSP_ID(4'd4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if.slave)
    );

    y86_regfile_wb #(.DATA_W(64), .NREGS(15), .CNT_W(2), .RSP_ID(4'd4)) dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s_if.slave)
    );

    typedef struct {
        int          kind;
        logic [63:0] exp;
        string       name;
    } chk_t;

    chk_t exp_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_v(input int kind, input logic [63:0] e, input string n);
        chk_t c;
        c.kind = kind;
        c.exp  = e;
        c.name = n;
        exp_q.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] ic, input logic c, input logic [3:0] a,
                         input logic [3:0] b, input logic [63:0] ve, input logic [63:0] vm);
        m_if.wb_valid = 1'b1;
        m_if.icode    = ic;
        m_if.cnd      = c;
        m_if.rA       = a;
        m_if.rB       = b;
        m_if.valE     = ve;
        m_if.valM     = vm;
        $display("tx icode=%h cnd=%0d rA=%h rB=%h valE=0x%0h valM=0x%0h", ic, c, a, b, ve, vm);
    endtask

    task automatic idle();
        m_if.wb_valid = 1'b0;
    endtask

    // Monitor: compare every pending expectation against the live outputs.
    always @(negedge clk) begin
        chk_t        c;
        logic [63:0] act;
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            case (c.kind)
                K_RDA:   act = m_if.rdA;
                K_RDB:   act = m_if.rdB;
                K_STAT:  act = 64'(m_if.stat);
                K_RET:   act = 64'(m_if.retired);
                K_READY: act = 64'(m_if.wb_ready);
                K_RET_S: act = 64'(s_if.retired);
                default: act = 'x;
            endcase
            chk_cnt++;
            if (act === c.exp)
                pass_cnt++;
            else
                $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, act, c.exp);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        m_if.wb_valid = 1'b0; m_if.icode = 4'h1; m_if.cnd = 1'b0;
        m_if.rA       = 4'hF; m_if.rB    = 4'hF;
        m_if.valE     = '0;   m_if.valM  = '0;
        m_if.srcA     = 4'h0; m_if.srcB  = 4'h0;
        s_if.wb_valid = 1'b0; s_if.icode = 4'h1; s_if.cnd = 1'b0;
        s_if.rA       = 4'hF; s_if.rB    = 4'hF;
        s_if.valE     = '0;   s_if.valM  = '0;
        s_if.srcA     = 4'h0; s_if.srcB  = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state: all 16 IDs read 0.
        for (int id = 0; id < 16; id++) begin
            m_if.srcA = 4'(id);
            m_if.srcB = 4'(15 - id);
            expect_v(K_RDA, 64'h0, $sformatf("reset_rdA_%0d", id));
            expect_v(K_RDB, 64'h0, $sformatf("reset_rdB_%0d", 15 - id));
            if (id == 0) begin
                expect_v(K_STAT, 64'd1, "reset_stat");
                expect_v(K_RET, 64'd0, "reset_retired");
                expect_v(K_READY, 64'd1, "reset_ready");
            end
            step();
        end

        // irmovq to reg 2: bypass then storage.
        issue(4'h3, 1'b0, 4'hF, 4'h2, 64'h1234, 64'h0);
        m_if.srcA = 4'h2; m_if.srcB = 4'h2;
        expect_v(K_RDA, 64'h1234, "irmovq_bypass_A");
        expect_v(K_RDB, 64'h1234, "irmovq_bypass_B");
        step();
        idle();
        expect_v(K_RDA, 64'h1234, "irmovq_stored");
        expect_v(K_RET, 64'd1, "irmovq_retired");
        step();

        // cmovXX with cnd=0 then cnd=1 into reg 3.
        issue(4'h2, 1'b0, 4'hF, 4'h3, 64'h55, 64'h0);
        m_if.srcA = 4'h3;
        expect_v(K_RDA, 64'h0, "cmov_nc_bypass");
        step();
        idle();
        expect_v(K_RDA, 64'h0, "cmov_nc_stored");
        expect_v(K_RET, 64'd2, "cmov_nc_retired");
        step();
        issue(4'h2, 1'b1, 4'hF, 4'h3, 64'h55, 64'h0);
        expect_v(K_RDA, 64'h55, "cmov_c_bypass");
        step();
        idle();
        expect_v(K_RDA, 64'h55, "cmov_c_stored");
        expect_v(K_RET, 64'd3, "cmov_c_retired");
        step();

        // popq %rsp: M wins over E.
        issue(4'hB, 1'b0, 4'h4, 4'hF, 64'h100, 64'hABC);
        m_if.srcA = 4'h4;
        expect_v(K_RDA, 64'hABC, "popq_rsp_bypass");
        step();
        idle();
        expect_v(K_RDA, 64'hABC, "popq_rsp_stored");
        expect_v(K_RET, 64'd4, "popq_rsp_retired");
        step();
        // popq %rcx: rsp gets valE, reg 1 gets valM.
        issue(4'hB, 1'b0, 4'h1, 4'hF, 64'h100, 64'hABC);
        m_if.srcA = 4'h4; m_if.srcB = 4'h1;
        expect_v(K_RDA, 64'h100, "popq_r1_bypass_rsp");
        expect_v(K_RDB, 64'hABC, "popq_r1_bypass_r1");
        step();
        idle();
        expect_v(K_RDA, 64'h100, "popq_r1_stored_rsp");
        expect_v(K_RDB, 64'hABC, "popq_r1_stored_r1");
        expect_v(K_RET, 64'd5, "popq_r1_retired");
        step();

        // OPq into reg 7, then mrmovq into reg 8.
        issue(4'h6, 1'b0, 4'hF, 4'h7, 64'h77, 64'h0);
        m_if.srcB = 4'h7;
        expect_v(K_RDB, 64'h77, "opq_bypass");
        step();
        issue(4'h5, 1'b0, 4'h8, 4'h7, 64'h99, 64'h88);
        m_if.srcA = 4'h8;
        expect_v(K_RDA, 64'h88, "mrmovq_bypass");
        expect_v(K_RDB, 64'h77, "opq_stored");
        step();
        idle();
        expect_v(K_RDA, 64'h88, "mrmovq_stored");
        expect_v(K_RET, 64'd7, "mrmovq_retired");
        step();

        // rmmovq writes nothing.
        issue(4'h4, 1'b0, 4'h9, 4'h9, 64'h99, 64'h98);
        m_if.srcA = 4'h9;
        expect_v(K_RDA, 64'h0, "rmmovq_bypass");
        step();
        idle();
        expect_v(K_RDA, 64'h0, "rmmovq_stored");
        expect_v(K_RET, 64'd8, "rmmovq_retired");
        step();

        // call updates rsp via port E.
        issue(4'h8, 1'b0, 4'hF, 4'hF, 64'h200, 64'h0);
        m_if.srcA = 4'h4;
        expect_v(K_RDA, 64'h200, "call_bypass");
        step();
        idle();
        expect_v(K_RDA, 64'h200, "call_stored");
        expect_v(K_RET, 64'd9, "call_retired");
        step();

        // halt, then an ignored irmovq to reg 5.
        issue(4'h0, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0);
        expect_v(K_READY, 64'd1, "halt_ready_before");
        expect_v(K_STAT, 64'd1, "halt_stat_before");
        step();
        issue(4'h3, 1'b0, 4'hF, 4'h5, 64'h555, 64'h0);
        m_if.srcA = 4'h5;
        expect_v(K_STAT, 64'd2, "halt_stat");
        expect_v(K_READY, 64'd0, "halt_ready");
        expect_v(K_RET, 64'd10, "halt_retired");
        expect_v(K_RDA, 64'h0, "halt_no_bypass");
        step();
        idle();
        expect_v(K_RDA, 64'h0, "halt_no_write");
        expect_v(K_RET, 64'd10, "halt_retired_frozen");
        expect_v(K_STAT, 64'd2, "halt_stat_hold");
        step();

        // Asynchronous reset pulse mid-cycle.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        expect_v(K_STAT, 64'd1, "rst_stat");
        expect_v(K_RET, 64'd0, "rst_retired");
        expect_v(K_READY, 64'd1, "rst_ready");
        for (int id = 0; id < 16; id++) begin
            m_if.srcA = 4'(id);
            expect_v(K_RDA, 64'h0, $sformatf("rst_reg_%0d", id));
            step();
        end

        // nop, then invalid instruction 4'hC.
        issue(4'h1, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0);
        step();
        issue(4'hC, 1'b0, 4'hF, 4'h6, 64'h66, 64'h0);
        m_if.srcA = 4'h6;
        expect_v(K_RDA, 64'h0, "ins_no_bypass");
        expect_v(K_RET, 64'd1, "ins_retired_before");
        step();
        idle();
        expect_v(K_STAT, 64'd4, "ins_stat");
        expect_v(K_READY, 64'd0, "ins_ready");
        expect_v(K_RET, 64'd1, "ins_retired_frozen");
        expect_v(K_RDA, 64'h0, "ins_no_write");
        step();

        // Saturation on the 2-bit counter instance.
        for (int k = 0; k < 5; k++) begin
            s_if.wb_valid = 1'b1;
            s_if.icode    = 4'h1;
            $display("tx small nop %0d", k);
            expect_v(K_RET_S, (k < 3) ? 64'(k) : 64'd3, $sformatf("sat_retired_%0d", k));
            step();
        end
        s_if.wb_valid = 1'b0;
        expect_v(K_RET_S, 64'd3, "sat_retired_final");
        step();

        step();
        if (exp_q.size() != 0) begin
            chk_cnt++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
